uart_tx: RTL

//  8N1 UART serial transmitter; the transmit-side companion to the team's UART receiver.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx.sv | 83 ++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic {IDLE, TRANSMITTING} uart_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// TX is a registered copy of the shift register LSB, so the line is glitch-free.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       busy,
    output logic       tx_done
);

    localparam int                BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [3:0]        LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    uart_state_t                 state, state_nxt;
    logic [BAUD_W-1:0]           baud_cnt, baud_cnt_nxt;
    logic [3:0]                  bit_cnt, bit_cnt_nxt;
    logic [UART_DATA_BITS:0]     shift_reg, shift_reg_nxt;
    logic                        tx_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
            tx_done   <= 1'b0;
            TX        <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_reg_nxt;
            tx_done   <= tx_done_nxt;
            TX        <= shift_reg[0];
        end
    end

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_cnt_nxt   = bit_cnt;
        shift_reg_nxt = shift_reg;
        tx_done_nxt   = tx_done;
        case (state)
            IDLE: begin
                if (trmt) begin
                    state_nxt     = TRANSMITTING;
                    shift_reg_nxt = {tx_data, 1'b0};
                    bit_cnt_nxt   = '0;
                    baud_cnt_nxt  = '0;
                    tx_done_nxt   = 1'b0;
                end
            end
            TRANSMITTING: begin
                if (baud_cnt == BAUD_LAST) begin
                    // Shifting in 1s leaves the register idling high once the frame ends.
                    baud_cnt_nxt  = '0;
                    shift_reg_nxt = {1'b1, shift_reg[UART_DATA_BITS:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt   = IDLE;
                        tx_done_nxt = 1'b1;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == TRANSMITTING);

endmodule
